// File: rtl/dmem_access_rv.sv
// dmem_access_rv: RV32I data-memory access unit. Takes one load/store at a time,
//   checks alignment and size, runs one word-wide req/ack bus transaction and
//   returns lane-extracted, sign/zero-extended load data with a one-cycle done pulse.
// Latency: 2 cycles minimum (zero-wait ack), 1 cycle for faults caught at accept,
//   TIMEOUT_CYCLES+1 for a bus timeout. Backpressure: owReqReady high only in IDLE.
// Ports: iwClk/iwRst (async active-high); request side iwReqValid/owReqReady with
//   iwAddr, iwWriteData, iwWrite, iwSignExtend, iwAccess; completion side owDone,
//   owReadData, owFault, owFaultCause; bus side owBusReq/iwBusAck, owBusAddr,
//   owBusWrite, owBusWData, owBusByteEn, iwBusRData.
module dmem_access_rv #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic        iwReqValid,
    output logic        owReqReady,
    input  logic [31:0] iwAddr,
    input  logic [31:0] iwWriteData,
    input  logic        iwWrite,
    input  logic        iwSignExtend,
    input  logic [1:0]  iwAccess,
    output logic        owDone,
    output logic [31:0] owReadData,
    output logic        owFault,
    output logic [1:0]  owFaultCause,
    output logic        owBusReq,
    output logic [31:0] owBusAddr,
    output logic        owBusWrite,
    output logic [31:0] owBusWData,
    output logic [3:0]  owBusByteEn,
    input  logic        iwBusAck,
    input  logic [31:0] iwBusRData
);

    localparam logic [1:0] ACC_BYTE = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_WORD = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int T_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    // Counter value seen in the last BUS cycle before a timeout completes
    localparam logic [CNT_W-1:0] T_LAST = T_LAST_I[CNT_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [31:0]       addr_q, wdata_q, rdata_q;
    logic              write_q, sext_q;
    logic [1:0]        acc_q, cause_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, misalign, illegal;
    logic              fin, use_rdata, cnt_clr, cnt_inc;
    logic [1:0]        cause_nxt;
    logic [31:0]       load_fmt, lane_wdata;
    logic [3:0]        lane_be;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              bus_act;

    assign accept   = (state == S_IDLE) && iwReqValid;
    assign illegal  = (iwAccess == 2'b11);
    assign misalign = ((iwAccess == ACC_HALF) && iwAddr[0]) ||
                      ((iwAccess == ACC_WORD) && (iwAddr[1:0] != 2'b00));

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fin       = 1'b0;
        use_rdata = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cause_nxt = CAUSE_NONE;
        case (state)
            S_IDLE: begin
                if (iwReqValid) begin
                    if (illegal) begin
                        state_nxt = S_DONE;
                        fin       = 1'b1;
                        cause_nxt = CAUSE_ILLEGAL;
                    end else if (misalign) begin
                        state_nxt = S_DONE;
                        fin       = 1'b1;
                        cause_nxt = CAUSE_MISALIGN;
                    end else begin
                        state_nxt = S_BUS;
                        cnt_clr   = 1'b1;
                    end
                end
            end
            S_BUS: begin
                if (iwBusAck) begin
                    state_nxt = S_DONE;
                    fin       = 1'b1;
                    use_rdata = !write_q;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == T_LAST)) begin
                    state_nxt = S_DONE;
                    fin       = 1'b1;
                    cause_nxt = CAUSE_TIMEOUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load lane extraction from the raw bus word, using the latched offset/size
    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: ld_byte = iwBusRData[7:0];
            2'd1: ld_byte = iwBusRData[15:8];
            2'd2: ld_byte = iwBusRData[23:16];
            2'd3: ld_byte = iwBusRData[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half  = addr_q[1] ? iwBusRData[31:16] : iwBusRData[15:0];
        load_fmt = iwBusRData;
        case (acc_q)
            ACC_BYTE: load_fmt = {{24{sext_q & ld_byte[7]}}, ld_byte};
            ACC_HALF: load_fmt = {{16{sext_q & ld_half[15]}}, ld_half};
            default:  load_fmt = iwBusRData;
        endcase
    end

    // Store lane replication and byte enables
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        case (acc_q)
            ACC_BYTE: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            ACC_HALF: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            sext_q  <= 1'b0;
            acc_q   <= 2'b00;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= iwAddr;
                wdata_q <= iwWriteData;
                write_q <= iwWrite;
                sext_q  <= iwSignExtend;
                acc_q   <= iwAccess;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Result registers update only on completion so they hold between pulses
            if (fin) begin
                cause_q <= cause_nxt;
                rdata_q <= use_rdata ? load_fmt : 32'h0;
            end
        end
    end

    // Bus outputs are forced to zero outside BUS so reset drops them at once
    assign bus_act      = (state == S_BUS);
    assign owBusReq     = bus_act;
    assign owBusAddr    = bus_act ? {addr_q[31:2], 2'b00} : 32'h0;
    assign owBusWrite   = bus_act & write_q;
    assign owBusWData   = bus_act ? lane_wdata : 32'h0;
    assign owBusByteEn  = bus_act ? lane_be : 4'b0000;

    assign owReqReady   = (state == S_IDLE) && !iwRst;
    assign owDone       = (state == S_DONE);
    assign owReadData   = rdata_q;
    assign owFaultCause = cause_q;
    assign owFault      = (cause_q != CAUSE_NONE);

endmodule

// File: doc/dmem_access_rv.md
# dmem_access_rv

Data-memory access unit for the RV32I core: the responder that executes the load/store control produced by the instruction decoder (write flag, sign-extend flag, access size). It accepts one request at a time from the execute stage. It checks alignment and issues a single word-wide bus transaction with byte enables and a req/ack handshake. It then returns load data that has been lane-extracted and sign- or zero-extended. A one-cycle completion pulse carries fault status.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for ack before faulting; 0 disables the timeout.

Ports:
- iwClk  in  1  clock; all state changes on rising edge.
- iwRst  in  1  reset, asynchronous, active-high.
- iwReqValid  in  1  request from the execute stage; accepted when owReqReady is high.
- owReqReady  out  1  high only in IDLE while iwRst is low.
- iwAddr  in  32  byte address (ALU result).
- iwWriteData  in  32  store data (rs2), low bits significant for byte and half-word stores.
- iwWrite  in  1  1 = store, 0 = load.
- iwSignExtend  in  1  load result sign-extended when 1, zero-extended when 0.
- iwAccess  in  2  `MEM_ACCESS_BYTE`, `MEM_ACCESS_HALF_WORD` or `MEM_ACCESS_WORD`; the fourth encoding is illegal.
- owDone  out  1  one-cycle completion pulse.
- owReadData  out  32  load result; valid with owDone, held until the next owDone.
- owFault  out  1  valid with owDone.
- owFaultCause  out  2  0 none, 1 misaligned, 2 timeout, 3 illegal size.
- owBusReq  out  1  bus request.
- owBusAddr  out  32  {addr[31:2], 2'b00}.
- owBusWrite  out  1  bus write.
- owBusWData  out  32  lane-replicated store data.
- owBusByteEn  out  4  active byte lanes.
- iwBusAck  in  1  bus acknowledge; sampled only while owBusReq is high.
- iwBusRData  in  32  bus read word; valid when iwBusAck is high.

## Operation
- FSM states are IDLE, BUS and DONE.
- IDLE, iwReqValid high: latch addr, wdata, write, sign-extend and access.
  - Misaligned access (half-word with addr[0]=1, word with addr[1:0]≠0) → DONE, cause 1, no bus cycle.
  - Illegal size → DONE, cause 3, no bus cycle.
  - Otherwise → BUS, clear the timeout counter.
- BUS: owBusReq high; all bus outputs stay stable from latched values until ack.
  - Ack high → capture and format the read data → DONE, cause 0.
  - Counter reaching TIMEOUT_CYCLES with no ack → drop req → DONE, cause 2.
  - Otherwise increment the counter (width ceil(log2(TIMEOUT_CYCLES+1)), no wrap).
- DONE: owDone=1 for exactly one cycle → IDLE.
- Lane formatting (o = addr[1:0]):
  - Byte: ByteEn = 4'b0001<<o; WData = {4{wdata[7:0]}}; load = rdata[8o+7:8o], extended.
  - Half-word: ByteEn = o[1] ? 4'b1100 : 4'b0011; WData = {2{wdata[15:0]}}; load = rdata[16·o[1]+15:16·o[1]], extended.
  - Word: ByteEn = 4'b1111; WData = wdata; load = rdata.
- Stores, faults and timeouts set owReadData to 0.
- owFault = (owFaultCause ≠ 0).
- Ack outside BUS is ignored.

## Timing
- Reset values:
  - State IDLE.
  - owReqReady=0 while iwRst is high, 1 after release.
  - owDone, owFault, owFaultCause, owReadData, owBusReq, owBusAddr, owBusWrite, owBusWData and owBusByteEn are all 0.
- Accept at edge 0. owBusReq is high from cycle 1. Ack sampled high at edge k (k≥1) gives owDone high in cycle k+1. Minimum latency is 2 cycles; with zero-wait ack, owDone is in cycle 2.
- A fault detected at accept gives owDone in cycle 1.
- A timeout gives owDone exactly TIMEOUT_CYCLES+1 cycles after accept.
- Back-to-back: the next request can be accepted in the cycle after owDone, so throughput is at most one access per 3 cycles.
- Reset mid-BUS or mid-DONE: owBusReq and owDone drop immediately (asynchronous). No completion pulse. Latched data is discarded.

## Test plan
- Load word, addr 0x1000, rdata 0x8899AABB, ack at first BUS cycle → owBusAddr 0x1000, ByteEn 1111; owDone in cycle 2 with owReadData 0x8899AABB, fault 0.
- LB from addr 0x1003, same rdata, iwSignExtend=1 → ByteEn 1000, owReadData 0xFFFFFF88. The same load with iwSignExtend=0 → 0x00000088.
- SH to addr 0x2002, wdata 0x12345678 → ByteEn 1100, WData 0x56785678, owBusWrite 1; ack delayed 5 cycles → owDone 6 cycles after ack-cycle start, owReadData 0.
- LW at 0x1001 → no owBusReq, owDone in cycle 1, cause 1. Illegal iwAccess → cause 3.
- TIMEOUT_CYCLES=4, ack never asserted → owBusReq high 4 cycles, then owDone with cause 2; a subsequent request is accepted normally.
- Assert iwRst during BUS → owBusReq low immediately, no owDone. After release, owReqReady=1 and a new load completes correctly.
